// File: rtl/hyperfabric_pkg.sv
// Shared types and constants for the hyperfabric block mover.
// State encoding, stall default and ancillary-word field layout.
package hyperfabric_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        RD_PUSH,
        WR_POP,
        WR_REQ,
        DONE
    } mvblck_state_t;

    localparam int STALL_LIMIT_DEF = 16;

    localparam int ANC_SEC_LSB = 23;
    localparam int ANC_DIR_BIT = 22;
    localparam int ANC_COL_LSB = 10;

    function automatic logic [24:0] pack_ancill(
        input logic [1:0]  sec,
        input logic        dir,
        input logic [11:0] col
    );
        logic [24:0] a;
        a = '0;
        a[ANC_SEC_LSB +: 2]  = sec;
        a[ANC_DIR_BIT]       = dir;
        a[ANC_COL_LSB +: 12] = col;
        return a;
    endfunction

endpackage

// File: rtl/block_mover_if.sv
// Command, DRAM and device-FIFO signals of one block-mover instance.
// slave is the mover; master is the controller/memory/fabric side.
interface block_mover_if;
    logic        MVBLCK_EN;
    logic        BLCK_ISSUE;
    logic [11:0] BLCK_START;
    logic [5:0]  BLCK_COUNT_REQ;
    logic [1:0]  BLCK_SECTION;
    logic [3:0]  SECTION_DIR;
    logic [5:0]  BLCK_COUNT_SENT;
    logic        BLCK_WORKING;
    logic        BLCK_IRQ;
    logic        BLCK_ABRUPT_STOP;
    logic        BLCK_FRDRAM_DEVERR;
    logic [24:0] BLCK_ANCILL;
    logic        DRAM_REQ;
    logic        DRAM_WE;
    logic [11:0] DRAM_COL;
    logic [31:0] DRAM_WDATA;
    logic        DRAM_ACK;
    logic [31:0] DRAM_RDATA;
    logic        DRAM_RVALID;
    logic [1:0]  DEV_SECTION;
    logic        DEV_WR_EN;
    logic [31:0] DEV_WDATA;
    logic        DEV_FULL;
    logic        DEV_RD_EN;
    logic [31:0] DEV_RDATA;
    logic        DEV_EMPTY;
    logic        DEV_END;
    logic        DEV_ERR;

    modport slave (
        input  MVBLCK_EN, BLCK_ISSUE, BLCK_START, BLCK_COUNT_REQ,
        input  BLCK_SECTION, SECTION_DIR,
        output BLCK_COUNT_SENT, BLCK_WORKING, BLCK_IRQ,
        output BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR, BLCK_ANCILL,
        output DRAM_REQ, DRAM_WE, DRAM_COL, DRAM_WDATA,
        input  DRAM_ACK, DRAM_RDATA, DRAM_RVALID,
        output DEV_SECTION, DEV_WR_EN, DEV_WDATA, DEV_RD_EN,
        input  DEV_FULL, DEV_RDATA, DEV_EMPTY, DEV_END, DEV_ERR
    );

    modport master (
        output MVBLCK_EN, BLCK_ISSUE, BLCK_START, BLCK_COUNT_REQ,
        output BLCK_SECTION, SECTION_DIR,
        input  BLCK_COUNT_SENT, BLCK_WORKING, BLCK_IRQ,
        input  BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR, BLCK_ANCILL,
        input  DRAM_REQ, DRAM_WE, DRAM_COL, DRAM_WDATA,
        output DRAM_ACK, DRAM_RDATA, DRAM_RVALID,
        input  DEV_SECTION, DEV_WR_EN, DEV_WDATA, DEV_RD_EN,
        output DEV_FULL, DEV_RDATA, DEV_EMPTY, DEV_END, DEV_ERR
    );
endinterface

// File: rtl/mvblck_stall_timer.sv
// Saturating count of consecutive device-side stall cycles.
// TC fires on the stall cycle that reaches LIMIT.
module mvblck_stall_timer #(
    parameter int LIMIT = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic CLR,
    input  logic INC,
    output logic TC
);
    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt <= '0;
        end else if (CLR) begin
            cnt <= '0;
        end else if (INC && cnt != LAST) begin
            cnt <= cnt + W'(1);
        end
    end

    assign TC = INC && (cnt == LAST);
endmodule

// File: rtl/block_mover.sv
// Gremlin block mover: moves up to 63 words between a DRAM page
// and a hyperfabric section FIFO, reporting count and status.
module block_mover
    import hyperfabric_pkg::*;
#(
    parameter int STALL_LIMIT = STALL_LIMIT_DEF
) (
    input logic         CLK,
    input logic         RST,
    block_mover_if.slave bus
);
    mvblck_state_t state;

    logic [11:0] col;
    logic [11:0] last_col;
    logic [5:0]  req_cnt;
    logic [5:0]  cnt;
    logic [5:0]  cnt_nxt;
    logic [1:0]  sec;
    logic        dir;
    logic [31:0] data;
    logic        end_flag;
    logic        pop_pend;
    logic        working;
    logic        irq;
    logic        abrupt;
    logic        deverr;

    logic rd_st, busy, push, pop, wr_done, word, fin;
    logic desel, err, stall, tc, dir_sel;

    always_comb begin
        rd_st   = state inside {RD_REQ, RD_WAIT, RD_PUSH};
        busy    = rd_st || state inside {WR_POP, WR_REQ};
        push    = (state == RD_PUSH) && !bus.DEV_FULL;
        pop     = (state == WR_POP) && !pop_pend && !bus.DEV_EMPTY;
        wr_done = (state == WR_REQ) && bus.DRAM_ACK;
        word    = push || wr_done;
        cnt_nxt = cnt + 6'd1;
        fin     = word && (cnt_nxt == req_cnt || (wr_done && end_flag));
        desel   = busy && !bus.MVBLCK_EN;
        err     = rd_st && bus.DEV_ERR;
        stall   = ((state == RD_PUSH) && bus.DEV_FULL) ||
                  ((state == WR_POP) && !pop_pend && bus.DEV_EMPTY);
        dir_sel = bus.SECTION_DIR[bus.BLCK_SECTION];
    end

    mvblck_stall_timer #(.LIMIT(STALL_LIMIT)) u_stall (
        .CLK (CLK),
        .RST (RST),
        .CLR (!stall),
        .INC (stall),
        .TC  (tc)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            col      <= '0;
            last_col <= '0;
            req_cnt  <= '0;
            cnt      <= '0;
            sec      <= '0;
            dir      <= 1'b0;
            data     <= '0;
            end_flag <= 1'b0;
            pop_pend <= 1'b0;
            working  <= 1'b0;
            irq      <= 1'b0;
            abrupt   <= 1'b0;
            deverr   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.BLCK_ISSUE && bus.MVBLCK_EN) begin
                        col      <= bus.BLCK_START;
                        req_cnt  <= bus.BLCK_COUNT_REQ;
                        sec      <= bus.BLCK_SECTION;
                        dir      <= dir_sel;
                        cnt      <= '0;
                        last_col <= '0;
                        end_flag <= 1'b0;
                        pop_pend <= 1'b0;
                        irq      <= 1'b0;
                        abrupt   <= 1'b0;
                        deverr   <= 1'b0;
                        working  <= 1'b1;
                        if (bus.BLCK_COUNT_REQ == '0) state <= DONE;
                        else if (dir_sel)             state <= RD_REQ;
                        else                          state <= WR_POP;
                    end
                end
                DONE: begin
                    working  <= 1'b0;
                    pop_pend <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    // A completing word always lands before any abort is flagged
                    if (word) begin
                        cnt      <= cnt_nxt;
                        last_col <= col;
                        col      <= col + 12'd1;
                    end
                    if (wr_done && end_flag) irq <= 1'b1;
                    if (desel || tc) abrupt <= 1'b1;
                    if (err) deverr <= 1'b1;
                    if (fin || desel || err || tc) begin
                        state    <= DONE;
                        pop_pend <= 1'b0;
                    end else if (state == RD_REQ) begin
                        if (bus.DRAM_ACK) state <= RD_WAIT;
                    end else if (state == RD_WAIT) begin
                        if (bus.DRAM_RVALID) begin
                            data  <= bus.DRAM_RDATA;
                            state <= RD_PUSH;
                        end
                    end else if (state == RD_PUSH) begin
                        if (push) state <= RD_REQ;
                    end else if (state == WR_POP) begin
                        if (pop_pend) begin
                            data     <= bus.DEV_RDATA;
                            end_flag <= bus.DEV_END;
                            pop_pend <= 1'b0;
                            state    <= WR_REQ;
                        end else if (pop) begin
                            pop_pend <= 1'b1;
                        end
                    end else if (wr_done) begin
                        state <= WR_POP;
                    end
                end
            endcase
        end
    end

    assign bus.DRAM_REQ   = (state == RD_REQ) || (state == WR_REQ);
    assign bus.DRAM_WE    = (state == WR_REQ);
    assign bus.DRAM_COL   = col;
    assign bus.DRAM_WDATA = data;
    assign bus.DEV_SECTION = sec;
    assign bus.DEV_WR_EN  = push;
    assign bus.DEV_WDATA  = data;
    assign bus.DEV_RD_EN  = pop;

    assign bus.BLCK_COUNT_SENT    = cnt;
    assign bus.BLCK_WORKING       = working;
    assign bus.BLCK_IRQ           = irq;
    assign bus.BLCK_ABRUPT_STOP   = abrupt;
    assign bus.BLCK_FRDRAM_DEVERR = deverr;
    assign bus.BLCK_ANCILL        = pack_ancill(sec, dir, last_col);
endmodule
